bi_set_arbiter: RTL and testbench

Multi-master front end for the BiSet configuration bus: arbitrates N requester ports round-robin onto the single BiSet master interface (ctrl/write out, reply in). It drives one transaction at a time and returns read data or a write acknowledge to the issuing requester. It sits where a single bus driver sits today, in front of the slave set (constants, registers, regfiles, status) and their reply mux.

---
 rtl/bi_set_arbiter_pkg.sv | 12 +
 rtl/biset_pkg.sv | 20 ++
 rtl/bi_set_rr_picker.sv | 25 ++
 rtl/bi_set_arbiter.sv | 146 ++++++++++++++
 tb/tb_bi_set_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bi_set_arbiter_pkg.sv
// Shared definitions for the BiSet multi-master arbiter.
package BiSetArb;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hffff_ffff;
  localparam int unsigned CNT_W        = 8;
endpackage

// File: rtl/biset_pkg.sv
// BiSet configuration bus types shared by every master and slave on the bus.
package BiSet;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
  } biSetCtrl;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } biSetData;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } biSetReply;
endpackage

// File: rtl/bi_set_rr_picker.sv
// Combinational round-robin picker: first valid requester after i_last, wrapping.
module bi_set_rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  int unsigned w_cand;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    o_idx  = '0;
    o_any  = |i_valid;
    w_cand = 0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      w_cand = (32'(i_last) + i) % N_REQ;
      if (i_valid[IDX_W'(w_cand)]) begin
        o_idx = IDX_W'(w_cand);
      end
    end
  end
endmodule

// File: rtl/bi_set_arbiter.sv
// Round-robin multi-master front end for the BiSet bus, one transaction at a time.
// Define BISET_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles without a reply.
module bi_set_arbiter
  import BiSet::*;
  import BiSetArb::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic [N_REQ-1:0]             req_write_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ-1:0][31:0]       req_data_i,
  output logic [N_REQ-1:0]             rsp_valid_o,
  output logic [31:0]                  rsp_data_o,
  output logic                         rsp_error_o,
  output biSetCtrl                     setCtrl_o,
  output biSetData                     setWrite_o,
  input  biSetReply                    setReply_i
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("bi_set_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bi_set_arbiter: TIMEOUT must be 1..255");
  end

  arb_state_e        r_state, w_state_next;
  logic [IDX_W-1:0]  r_last, r_winner, w_pick;
  logic              w_any, w_accept, w_timeout;
  logic              r_write, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;

  bi_set_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_valid (req_valid_i),
    .i_last  (r_last),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any && !rst_i;

`ifdef BISET_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Counter sits at zero outside WAIT, so it is cleared on every entry to WAIT.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (r_state == WAIT) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready_o[w_pick] = 1'b1;
          w_state_next        = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (setReply_i.valid || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_last   <= IDX_W'(N_REQ - 1);
      r_winner <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_winner <= w_pick;
            r_write  <= req_write_i[w_pick];
            r_addr   <= req_addr_i[w_pick];
            r_wdata  <= req_data_i[w_pick];
          end
        end
        ISSUE: r_last <= r_winner;
        WAIT: begin
          // A reply in the expiry cycle takes priority over the timeout.
          if (setReply_i.valid) begin
            r_rdata <= r_write ? '0 : setReply_i.data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= TIMEOUT_DATA;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    setCtrl_o   = '0;
    setWrite_o  = '0;
    rsp_valid_o = '0;
    if (r_state == ISSUE) begin
      setCtrl_o.addr  = r_addr;
      setCtrl_o.wr    = r_write;
      setCtrl_o.rd    = !r_write;
      setWrite_o.data = r_write ? r_wdata : '0;
    end
    if (r_state == RESP) begin
      rsp_valid_o[r_winner] = 1'b1;
    end
  end

  assign rsp_data_o  = r_rdata;
  assign rsp_error_o = (r_state == RESP) && r_err;
endmodule

// File: tb/tb_bi_set_arbiter.sv
// Directed bench for bi_set_arbiter with a small BiSet slave set model.
module tb_bi_set_arbiter;
  import BiSet::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [3:0]             req_valid = '0;
  logic [3:0]             req_ready;
  logic [3:0]             req_write = '0;
  logic [3:0][ADDR_W-1:0] req_addr  = '0;
  logic [3:0][31:0]       req_data  = '0;
  logic [3:0]             rsp_valid;
  logic [31:0]            rsp_data;
  logic                   rsp_error;
  biSetCtrl               set_ctrl;
  biSetData               set_write;
  biSetReply              set_reply = '0;

  bi_set_arbiter #(
    .N_REQ   (4),
    .TIMEOUT (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_error_o (rsp_error),
    .setCtrl_o   (set_ctrl),
    .setWrite_o  (set_write),
    .setReply_i  (set_reply)
  );

  always #5 clk = ~clk;

  // Slave set: addr 1 constant, addr 2 register, everything else unmapped.
  int          lat = 1;
  int          sl_left = 0;
  logic [ADDR_W-1:0] sl_addr = '0;
  logic        sl_wr = 1'b0;
  logic [31:0] sl_reg2 = 32'haffebabe;

  function automatic biSetReply slave_reply(input logic [ADDR_W-1:0] a, input logic wr,
                                            input logic [31:0] r2);
    slave_reply = '0;
    if (a == 1 || a == 2) begin
      slave_reply.valid = 1'b1;
      slave_reply.data  = wr ? 32'hbad0bad0 : ((a == 1) ? 32'hdeadaffe : r2);
    end
  endfunction

  always @(posedge clk) begin
    set_reply <= '0;
    if (rst) begin
      sl_left <= 0;
      sl_reg2 <= 32'haffebabe;
    end else if (set_ctrl.rd || set_ctrl.wr) begin
      sl_addr <= set_ctrl.addr;
      sl_wr   <= set_ctrl.wr;
      if (set_ctrl.wr && set_ctrl.addr == 2) sl_reg2 <= set_write.data;
      if (lat == 1) set_reply <= slave_reply(set_ctrl.addr, set_ctrl.wr, sl_reg2);
      else          sl_left   <= lat - 1;
    end else if (sl_left > 0) begin
      sl_left <= sl_left - 1;
      if (sl_left == 1) set_reply <= slave_reply(sl_addr, sl_wr, sl_reg2);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event log filled by step(); cycle numbers are step counts.
  int          cyc = 0;
  int          grants[$];
  int          acc_q[$];
  int          n_issue = 0, issue_cyc = 0;
  logic        issue_wr = 1'b0;
  logic [31:0] issue_wdata = '0;
  int          n_rsp = 0, rsp_cyc = 0, rsp_idx = 0;
  logic        rsp_now = 1'b0, rsp_err_s = 1'b0;
  logic [31:0] rsp_data_s = '0;

  function automatic int oh2idx(input logic [3:0] v);
    oh2idx = -1;
    for (int i = 0; i < 4; i++) if (v[i]) oh2idx = i;
  endfunction

  task automatic step();
    logic [3:0] rdy;
    @(negedge clk);
    rdy     = req_ready;
    rsp_now = 1'b0;
    if (|req_ready) begin
      check("ready_onehot", $countones(req_ready), 1);
      grants.push_back(oh2idx(req_ready));
      acc_q.push_back(cyc);
    end
    if (set_ctrl.rd || set_ctrl.wr) begin
      n_issue++;
      issue_cyc   = cyc;
      issue_wr    = set_ctrl.wr;
      issue_wdata = set_write.data;
    end
    if (|rsp_valid) begin
      check("rsp_onehot", $countones(rsp_valid), 1);
      n_rsp++;
      rsp_now    = 1'b1;
      rsp_cyc    = cyc;
      rsp_idx    = oh2idx(rsp_valid);
      rsp_data_s = rsp_data;
      rsp_err_s  = rsp_error;
    end
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~rdy;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n0;
    n0 = n_rsp;
    for (int i = 0; i < budget && n_rsp == n0; i++) step();
    if (n_rsp == n0) check({tag, "_timeout"}, 0, 1);
  endtask

  int g0, n0i, n0r;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ctrl", set_ctrl, 0);
    check("rst_write", set_write, 0);
    rst = 1'b0;
    step();

    // Requester 0 reads the constant at address 1
    g0 = grants.size(); n0i = n_issue;
    req_write[0] = 1'b0; req_addr[0] = 1; req_valid[0] = 1'b1;
    wait_rsp("rd0", 20);
    check("rd0_grant", grants[g0], 0);
    check("rd0_issues", n_issue - n0i, 1);
    check("rd0_issue_lat", issue_cyc - acc_q[g0], 1);
    check("rd0_rsp_lat", rsp_cyc - acc_q[g0], 3);
    check("rd0_idx", rsp_idx, 0);
    check("rd0_data", rsp_data_s, 32'hdeadaffe);
    check("rd0_err", rsp_err_s, 0);
    step();

    // Requester 2 writes the register, requester 1 reads it back
    g0 = grants.size();
    req_write[2] = 1'b1; req_addr[2] = 2; req_data[2] = 32'h12345678; req_valid[2] = 1'b1;
    wait_rsp("wr2", 20);
    check("wr2_grant", grants[g0], 2);
    check("wr2_bus_wr", issue_wr, 1);
    check("wr2_bus_data", issue_wdata, 32'h12345678);
    check("wr2_idx", rsp_idx, 2);
    check("wr2_ack_data", rsp_data_s, 0);
    check("wr2_err", rsp_err_s, 0);
    req_write[2] = 1'b0;
    req_write[1] = 1'b0; req_addr[1] = 2; req_valid[1] = 1'b1;
    wait_rsp("rd1", 20);
    check("rd1_grant", grants[g0 + 1], 1);
    check("rd1_bus_wdata", issue_wdata, 0);
    check("rd1_idx", rsp_idx, 1);
    check("rd1_data", rsp_data_s, 32'h12345678);
    step();

    // Reply in the last WAIT cycle before expiry: rsp 33 cycles after ISSUE, no error
    lat = 32;
    req_addr[0] = 1; req_valid[0] = 1'b1;
    wait_rsp("slow", 60);
    check("slow_lat", rsp_cyc - issue_cyc, 33);
    check("slow_err", rsp_err_s, 0);
    check("slow_data", rsp_data_s, 32'hdeadaffe);
    step();

    // Requester 1 withdraws while requester 0 is busy
    lat = 6; g0 = grants.size(); n0i = n_issue;
    req_addr[0] = 1; req_valid[0] = 1'b1;
    step(); step();
    req_addr[1] = 1; req_valid[1] = 1'b1;
    step(); step();
    req_valid[1] = 1'b0;
    wait_rsp("drop", 20);
    repeat (6) step();
    check("drop_issues", n_issue - n0i, 1);
    check("drop_grants", grants.size() - g0, 1);
    check("drop_who", grants[g0], 0);

    // Reset during WAIT of requester 1's read aborts silently
    lat = 5; n0r = n_rsp;
    req_addr[1] = 1; req_valid[1] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ctrl", set_ctrl, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    repeat (8) step();
    check("abort_no_rsp", n_rsp - n0r, 0);
    lat = 1; g0 = grants.size();
    req_addr[0] = 1; req_addr[2] = 1;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    step();
    check("abort_next_grant", (grants.size() > g0) ? grants[g0] : -1, 0);
    wait_rsp("abort_a", 20);
    wait_rsp("abort_b", 20);
    step();

    // All four requesters contend from reset
    rst = 1'b1;
    req_addr = {4{8'd1}}; req_write = '0; req_valid = '1;
    step(); step();
    rst = 1'b0;
    g0 = grants.size();
    for (int i = 0; i < 60 && grants.size() < g0 + 5; i++) begin
      step();
      if (rsp_now) req_valid[rsp_idx] = 1'b1;
    end
    req_valid = '0;
    check("rr_count", grants.size() - g0, 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order%0d", k), (grants.size() > g0 + k) ? grants[g0 + k] : -1, k % 4);
    end
    check("rr_turnaround", (acc_q.size() > g0 + 1) ? acc_q[g0 + 1] - acc_q[g0] : -1, 4);
    wait_rsp("rr_tail", 20);
    step();

    // Requester 3 reads unmapped address 7
    g0 = grants.size(); n0i = n_issue; n0r = n_rsp;
    req_addr[3] = 7; req_valid[3] = 1'b1;
`ifdef BISET_ARB_TIMEOUT_EN
    wait_rsp("to", 60);
    check("to_grant", grants[g0], 3);
    check("to_lat", rsp_cyc - issue_cyc, 33);
    check("to_idx", rsp_idx, 3);
    check("to_err", rsp_err_s, 1);
    check("to_data", rsp_data_s, 32'hffffffff);
`else
    repeat (110) step();
    check("hang_grant", grants[g0], 3);
    check("hang_issues", n_issue - n0i, 1);
    check("hang_no_rsp", n_rsp - n0r, 0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("final_ctrl", set_ctrl, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
